corg_exec_ctrl: RTL and testbench
=================================

CORG_EXEC_CTRL -- requirements
Module: corg_exec_ctrl

Interface
REQ-001 Parameter DATA_W, default 16: datapath and register width.
REQ-002 Parameter REG_N, default 8: number of architectural registers; address width is log2(REG_N)=3.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  decoded instruction present.
REQ-006 in_ready  output  1  block accepts instruction this cycle.
REQ-007 in_op  input  3  ALU operation: 000 add, 001 and, 010 sub, 011 or, 100 xor, 101 sll, 110 slt, 111 illegal.
REQ-008 in_rd / in_rs / in_rt  input  3 each  destination and source register addresses.
REQ-009 in_use_imm  input  1  selects the immediate instead of rt for operand b.
REQ-010 in_imm  input  6  immediate, zero-extended to DATA_W.
REQ-011 alu_op  output  3  operation driven to the external combinational ALU.
REQ-012 alu_a / alu_b  output  DATA_W  operands driven to the ALU.
REQ-013 alu_result  input  DATA_W  ALU result, combinational from alu_op/alu_a/alu_b.
REQ-014 wb_valid  output  1  one-cycle writeback pulse.
REQ-015 wb_rd / wb_data  output  3 / DATA_W  writeback address and value.
REQ-016 err  output  1  one-cycle pulse for an illegal opcode.
REQ-017 dbg_addr / dbg_data  input 3 / output DATA_W  combinational register read port.

Function
REQ-018 FSM states: IDLE, READ, EXEC, WB; transitions are IDLE->READ on in_valid&in_ready, then READ->EXEC->WB->IDLE unconditionally.
REQ-019 in_ready shall be 1 only in IDLE; in_valid in any other state is ignored and the instruction is not captured.
REQ-020 At acceptance (edge E0), op, rd, rs, rt, use_imm and imm shall be latched.
REQ-021 READ: at E1, operand a = R[rs] and operand b = use_imm ? zext(imm) : R[rt] shall be latched into registers driving alu_a/alu_b; alu_op is registered at the same edge.
REQ-022 EXEC: alu_result shall be sampled at E2 into the result register.
REQ-023 WB: wb_valid=1, wb_rd=rd, wb_data=result for exactly one cycle; the register file is written at E3 and the state returns to IDLE.
REQ-024 Throughput is one instruction per 4 cycles; the earliest next acceptance edge is E4.
REQ-025 R0 shall always read 0; writes to R0 are discarded, but wb_valid still pulses with the computed wb_data.
REQ-026 Op 111: no register write, wb_valid=0, and err=1 during WB; timing is otherwise identical.
REQ-027 During WB, dbg_data for rd returns the old value; the new value is visible from the cycle after E3.
REQ-028 A source register equal to the previous rd reads the updated value, because writeback completes before the next READ.
REQ-029 All arithmetic is modulo 2^DATA_W; the block performs no sign or width extension other than zero-extending the immediate.

Reset
REQ-030 When rst=1 at an edge: state goes to IDLE, all registers R0..R7 and operand, op and result registers go to 0, and wb_valid, err and alu_op go to 0.
REQ-031 Reset asserted in any state shall abort the in-flight instruction with no register write and no wb_valid.
REQ-032 in_ready shall be 1 in the first cycle after rst deasserts.

Structure
REQ-033 Opcode constants (ALU_ADD..ALU_SLT, ALU_ILL), FSM state encodings, DATA_W and REG_N shall live in the shared package corg_pkg, also used by the ALU.
REQ-034 The register file shall be the sub-module corg_regfile: 2 combinational read ports plus 1 debug read port, 1 synchronous write port, R0 hardwired to zero, and synchronous reset.

Verification
REQ-035 Bench shall use a behavioural ALU model covering all 8 opcodes and check timing as well as values.
REQ-036 After reset, add rd=1, rs=0, imm=0x15 -> in_ready=0 for 3 cycles; wb_valid in the 4th cycle with wb_rd=1 and wb_data=0x0015; dbg R1=0x0015 afterwards.
REQ-037 Back-to-back dependent instructions: sub r2=r1-imm 0x20 -> wb_data=0xFFF5; sll r3=r1<<imm 3 -> 0x00A8; slt r4=r2,r1 with rt -> 0x0001 (signed compare in the model).
REQ-038 Op 111 with rd=5 -> err pulses once, wb_valid stays 0, and R5 is unchanged; add rd=0, rs=1, imm=1 -> wb_data=0x0016 while R0 stays 0.
REQ-039 in_valid held high continuously with changing fields -> only the instructions present in IDLE cycles are accepted, one per 4 cycles.
REQ-040 rst pulsed during EXEC of add r6=r1+imm 1 -> no wb_valid, R6=0, all registers 0, in_ready=1 in the next cycle.

Source files
------------

// File: rtl/corg_pkg.sv
// Shared constants and types for the corg execute control block.
// Also used by the external ALU for opcode decoding.
package corg_pkg;

  localparam int DATA_W = 16;
  localparam int REG_N  = 8;
  localparam int IMM_W  = 6;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_AND = 3'b001,
    ALU_SUB = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SLL = 3'b101,
    ALU_SLT = 3'b110,
    ALU_ILL = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_EXEC = 2'd2,
    S_WB   = 2'd3
  } state_e;

endpackage

// File: rtl/corg_regfile.sv
// Architectural register file: two operand read ports, one debug
// read port, one synchronous write port, R0 hardwired to zero.
module corg_regfile #(
  parameter int DATA_W = 16,
  parameter int REG_N  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [$clog2(REG_N)-1:0] waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [$clog2(REG_N)-1:0] raddr_a,
  output logic [DATA_W-1:0]        rdata_a,
  input  logic [$clog2(REG_N)-1:0] raddr_b,
  output logic [DATA_W-1:0]        rdata_b,
  input  logic [$clog2(REG_N)-1:0] dbg_addr,
  output logic [DATA_W-1:0]        dbg_data
);

  logic [DATA_W-1:0] mem [REG_N];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_N; i++) mem[i] <= '0;
    end else if (we && waddr != '0) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_a  = (raddr_a  == '0) ? '0 : mem[raddr_a];
  assign rdata_b  = (raddr_b  == '0) ? '0 : mem[raddr_b];
  assign dbg_data = (dbg_addr == '0) ? '0 : mem[dbg_addr];

endmodule

// File: rtl/corg_exec_ctrl.sv
// Multi-cycle execute controller: accept, read operands, run the
// external ALU, write back. One instruction every four cycles.
module corg_exec_ctrl
  import corg_pkg::*;
#(
  parameter int DATA_W = corg_pkg::DATA_W,
  parameter int REG_N  = corg_pkg::REG_N
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [2:0]               in_op,
  input  logic [$clog2(REG_N)-1:0] in_rd,
  input  logic [$clog2(REG_N)-1:0] in_rs,
  input  logic [$clog2(REG_N)-1:0] in_rt,
  input  logic                     in_use_imm,
  input  logic [IMM_W-1:0]         in_imm,
  output logic [2:0]               alu_op,
  output logic [DATA_W-1:0]        alu_a,
  output logic [DATA_W-1:0]        alu_b,
  input  logic [DATA_W-1:0]        alu_result,
  output logic                     wb_valid,
  output logic [$clog2(REG_N)-1:0] wb_rd,
  output logic [DATA_W-1:0]        wb_data,
  output logic                     err,
  input  logic [$clog2(REG_N)-1:0] dbg_addr,
  output logic [DATA_W-1:0]        dbg_data
);

  localparam int AW = $clog2(REG_N);

  state_e            state, state_nxt;
  alu_op_e           op_q, alu_op_q;
  logic [AW-1:0]     rd_q, rs_q, rt_q;
  logic              use_imm_q;
  logic [IMM_W-1:0]  imm_q;
  logic [DATA_W-1:0] a_q, b_q, res_q;
  logic [DATA_W-1:0] rs_data, rt_data;
  logic              rf_we;

  assign rf_we = (state == S_WB) && (op_q != ALU_ILL);

  corg_regfile #(
    .DATA_W(DATA_W),
    .REG_N (REG_N)
  ) u_rf (
    .clk     (clk),
    .rst     (rst),
    .we      (rf_we),
    .waddr   (rd_q),
    .wdata   (res_q),
    .raddr_a (rs_q),
    .rdata_a (rs_data),
    .raddr_b (rt_q),
    .rdata_b (rt_data),
    .dbg_addr(dbg_addr),
    .dbg_data(dbg_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      op_q      <= ALU_ADD;
      alu_op_q  <= ALU_ADD;
      rd_q      <= '0;
      rs_q      <= '0;
      rt_q      <= '0;
      use_imm_q <= 1'b0;
      imm_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      res_q     <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && in_valid) begin
        op_q      <= alu_op_e'(in_op);
        rd_q      <= in_rd;
        rs_q      <= in_rs;
        rt_q      <= in_rt;
        use_imm_q <= in_use_imm;
        imm_q     <= in_imm;
      end
      if (state == S_READ) begin
        a_q      <= rs_data;
        b_q      <= use_imm_q
                  ? {{(DATA_W-IMM_W){1'b0}}, imm_q}
                  : rt_data;
        alu_op_q <= op_q;
      end
      if (state == S_EXEC) res_q <= alu_result;
    end
  end

  // Writeback strobes are masked by rst so an aborted WB never shows.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    wb_valid  = 1'b0;
    err       = 1'b0;
    unique case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = S_READ;
      end
      S_READ: state_nxt = S_EXEC;
      S_EXEC: state_nxt = S_WB;
      S_WB: begin
        wb_valid  = !rst && (op_q != ALU_ILL);
        err       = !rst && (op_q == ALU_ILL);
        state_nxt = S_IDLE;
      end
    endcase
  end

  assign alu_op  = alu_op_q;
  assign alu_a   = a_q;
  assign alu_b   = b_q;
  assign wb_rd   = rd_q;
  assign wb_data = res_q;

endmodule

// File: tb/tb_corg_exec_ctrl.sv
// Randomised bench for corg_exec_ctrl with a behavioural ALU and a
// transaction-level register model.
module tb_corg_exec_ctrl;
  import corg_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [2:0]  in_rd, in_rs, in_rt;
  logic        in_use_imm;
  logic [5:0]  in_imm;
  logic [2:0]  alu_op;
  logic [15:0] alu_a, alu_b, alu_result;
  logic        wb_valid;
  logic [2:0]  wb_rd;
  logic [15:0] wb_data;
  logic        err;
  logic [2:0]  dbg_addr;
  logic [15:0] dbg_data;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] mdl [8];
  logic [15:0] wbd;

  always #5 clk = ~clk;

  function automatic logic [15:0] alu_f(
    input logic [2:0] op,
    input logic [15:0] a,
    input logic [15:0] b
  );
    case (op)
      3'd0: return a + b;
      3'd1: return a & b;
      3'd2: return a - b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return a << b;
      3'd6: return ($signed(a) < $signed(b)) ? 16'd1 : 16'd0;
      default: return 16'd0;
    endcase
  endfunction

  assign alu_result = alu_f(alu_op, alu_a, alu_b);

  corg_exec_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_rd     (in_rd),
    .in_rs     (in_rs),
    .in_rt     (in_rt),
    .in_use_imm(in_use_imm),
    .in_imm    (in_imm),
    .alu_op    (alu_op),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_result(alu_result),
    .wb_valid  (wb_valid),
    .wb_rd     (wb_rd),
    .wb_data   (wb_data),
    .err       (err),
    .dbg_addr  (dbg_addr),
    .dbg_data  (dbg_data)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic noise_fields();
    in_valid   = 1'($urandom);
    in_op      = 3'($urandom);
    in_rd      = 3'($urandom);
    in_rs      = 3'($urandom);
    in_rt      = 3'($urandom);
    in_use_imm = 1'($urandom);
    in_imm     = 6'($urandom);
  endtask

  // Called at a negedge in IDLE; returns at the next IDLE negedge.
  task automatic run_instr(
    input  logic [2:0]  op,
    input  logic [2:0]  rd,
    input  logic [2:0]  rs,
    input  logic [2:0]  rt,
    input  logic        ui,
    input  logic [5:0]  imm,
    input  bit          noise,
    output logic [15:0] wbo
  );
    logic [15:0] a, b, exp, old;
    a   = mdl[rs];
    b   = ui ? {10'd0, imm} : mdl[rt];
    exp = alu_f(op, a, b);
    old = mdl[rd];
    wbo = 16'hxxxx;
    chk("rdy_idle", 32'(in_ready), 32'd1);
    in_valid   = 1'b1;
    in_op      = op;
    in_rd      = rd;
    in_rs      = rs;
    in_rt      = rt;
    in_use_imm = ui;
    in_imm     = imm;
    dbg_addr   = rd;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk("rdy_busy", 32'(in_ready), 32'd0);
      chk("wb_valid", 32'(wb_valid),
          32'(k == 3 && op != 3'd7));
      chk("err", 32'(err), 32'(k == 3 && op == 3'd7));
      if (k == 2) begin
        chk("alu_op", 32'(alu_op), 32'(op));
        chk("alu_a", 32'(alu_a), 32'(a));
        chk("alu_b", 32'(alu_b), 32'(b));
      end
      if (k == 3) begin
        if (op != 3'd7) begin
          chk("wb_rd", 32'(wb_rd), 32'(rd));
          chk("wb_data", 32'(wb_data), 32'(exp));
        end
        chk("dbg_old", 32'(dbg_data), 32'(old));
        wbo = wb_data;
      end
      if (noise) noise_fields();
      else in_valid = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
    if (op != 3'd7 && rd != 3'd0) mdl[rd] = exp;
    chk("dbg_new", 32'(dbg_data), 32'(mdl[rd]));
    chk("wb_idle", 32'(wb_valid), 32'd0);
    chk("rdy_back", 32'(in_ready), 32'd1);
  endtask

  task automatic chk_all_regs(input string tag);
    for (int i = 0; i < 8; i++) begin
      dbg_addr = 3'(i);
      #1;
      chk(tag, 32'(dbg_data), 32'(mdl[i]));
    end
  endtask

  initial begin
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_op      = '0;
    in_rd      = '0;
    in_rs      = '0;
    in_rt      = '0;
    in_use_imm = 1'b0;
    in_imm     = '0;
    dbg_addr   = '0;
    for (int i = 0; i < 8; i++) mdl[i] = '0;

    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_rdy", 32'(in_ready), 32'd1);
    chk("rst_wbv", 32'(wb_valid), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_aluop", 32'(alu_op), 32'd0);
    chk("rst_alua", 32'(alu_a), 32'd0);
    chk("rst_alub", 32'(alu_b), 32'd0);
    chk_all_regs("rst_reg");

    run_instr(3'd0, 3'd1, 3'd0, 3'd0, 1'b1, 6'h15, 1'b0, wbd);
    chk("add_r1", 32'(wbd), 32'h0015);
    run_instr(3'd2, 3'd2, 3'd1, 3'd0, 1'b1, 6'h20, 1'b0, wbd);
    chk("sub_r2", 32'(wbd), 32'hFFF5);
    run_instr(3'd5, 3'd3, 3'd1, 3'd0, 1'b1, 6'd3, 1'b0, wbd);
    chk("sll_r3", 32'(wbd), 32'h00A8);
    run_instr(3'd6, 3'd4, 3'd2, 3'd1, 1'b0, 6'd0, 1'b0, wbd);
    chk("slt_r4", 32'(wbd), 32'h0001);
    run_instr(3'd7, 3'd5, 3'd1, 3'd2, 1'b1, 6'd9, 1'b0, wbd);
    dbg_addr = 3'd5;
    #1;
    chk("ill_r5", 32'(dbg_data), 32'h0000);
    run_instr(3'd0, 3'd0, 3'd1, 3'd0, 1'b1, 6'd1, 1'b0, wbd);
    chk("add_r0_wb", 32'(wbd), 32'h0016);
    dbg_addr = 3'd0;
    #1;
    chk("r0_zero", 32'(dbg_data), 32'h0000);

    for (int n = 0; n < 40; n++) begin
      run_instr(3'($urandom), 3'($urandom), 3'($urandom),
                3'($urandom), 1'($urandom), 6'($urandom),
                1'b1, wbd);
    end
    in_valid = 1'b0;
    chk_all_regs("rand_reg");

    // Abort an add r6=r1+1 while it is in EXEC.
    in_valid   = 1'b1;
    in_op      = 3'd0;
    in_rd      = 3'd6;
    in_rs      = 3'd1;
    in_use_imm = 1'b1;
    in_imm     = 6'd1;
    dbg_addr   = 3'd6;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("abort_alua", 32'(alu_a), 32'(mdl[1]));
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) mdl[i] = '0;
    chk("abort_rdy", 32'(in_ready), 32'd1);
    chk("abort_wbv", 32'(wb_valid), 32'd0);
    chk("abort_err", 32'(err), 32'd0);
    chk_all_regs("abort_reg");
    @(posedge clk);
    @(negedge clk);
    chk("abort_wbv2", 32'(wb_valid), 32'd0);
    chk("abort_rdy2", 32'(in_ready), 32'd1);

    for (int n = 0; n < 6; n++) begin
      run_instr(3'($urandom), 3'($urandom), 3'($urandom),
                3'($urandom), 1'($urandom), 6'($urandom),
                1'b1, wbd);
    end
    in_valid = 1'b0;
    chk_all_regs("final_reg");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
